// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RISC-V core constants and the commit-trace record type.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN         = 32;
    localparam int TRACE_DROP_W = 16;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic [31:0]     seq;
    } commit_rec_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/trace_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo_ram
//  Description : DEPTH x WIDTH register array, one write port, one async read.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Storage is deliberately left unreset; pointers alone define validity.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : trace_fifo_ram
`default_nettype wire

// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_fifo
//  Description : Captures retired instructions into a drop-on-overflow FWFT
//                FIFO with sequence tags. Option: COMMIT_TRACE_X0_FILTER_EN
//                zeroes rd_data for records whose destination is x0.
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         update_i,
    input  logic [XLEN-1:0]              pc_i,
    input  logic [XLEN-1:0]              instr_i,
    input  logic [4:0]                   reg_addr_i,
    input  logic [XLEN-1:0]              reg_data_i,
    output logic                         trace_valid_o,
    input  logic                         trace_ready_i,
    output commit_rec_t                  trace_rec_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic [TRACE_DROP_W-1:0]      drop_cnt_o,
    output logic                         overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int RW = $bits(commit_rec_t);

    logic [AW:0]             r_wptr;
    logic [AW:0]             r_rptr;
    logic [SEQ_W-1:0]        r_seq;
    logic [TRACE_DROP_W-1:0] r_drop_cnt;
    logic                    r_overflow;

    logic [AW:0]             w_level;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [XLEN-1:0]         w_rd_data;
    commit_rec_t             w_rec_in;
    logic [RW-1:0]           w_rec_out;

    // Extra pointer MSB lets the difference reach DEPTH without aliasing to 0.
    assign w_level = r_wptr - r_rptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == (AW+1)'(DEPTH));
    assign w_pop   = !w_empty && trace_ready_i;
    assign w_push  = update_i && (!w_full || w_pop);
    assign w_drop  = update_i && w_full && !w_pop;

`ifdef COMMIT_TRACE_X0_FILTER_EN
    assign w_rd_data = (reg_addr_i == 5'd0) ? '0 : reg_data_i;
`else
    assign w_rd_data = reg_data_i;
`endif

    always_comb begin
        w_rec_in         = '0;
        w_rec_in.pc      = pc_i;
        w_rec_in.instr   = instr_i;
        w_rec_in.rd      = reg_addr_i;
        w_rec_in.rd_data = w_rd_data;
        w_rec_in.seq     = 32'(r_seq);
    end

    trace_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_ram (
        .clk     (clk_i),
        .i_we    (w_push && !rst_i),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (w_rec_in),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rec_out)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_seq      <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Every retire consumes a sequence number so drops leave gaps.
            if (update_i) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_drop) begin
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
                r_overflow <= 1'b1;
            end
        end
    end

    assign trace_valid_o = !w_empty;
    assign trace_rec_o   = commit_rec_t'(w_rec_out);
    assign level_o       = LW'(w_level);
    assign drop_cnt_o    = r_drop_cnt;
    assign overflow_o    = r_overflow;

endmodule : commit_trace_fifo
`default_nettype wire

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Downstream of the RISC-V core model's retire port. Each cycle the core asserts its update strobe, this block captures the retired instruction as one record: PC, instruction word, destination register and written value. Records are held in a small FIFO and drained over a valid/ready interface to a trace sink such as a log writer or a lock-step checker. The core cannot be stalled, so the block drops records on overflow, counts the drops, and tags every record with a sequence number so that gaps are visible.

## Interface
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SEQ_W, 32, sequence-number width.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- update_i  in  1  retire strobe from the core (update_o).
- pc_i  in  riscv_pkg::XLEN  retired PC.
- instr_i  in  riscv_pkg::XLEN  retired instruction word.
- reg_addr_i  in  5  destination register; 0 means no write-back.
- reg_data_i  in  riscv_pkg::XLEN  write-back value.
- trace_valid_o  out  1  head record available.
- trace_ready_i  in  1  sink accepts the head record.
- trace_rec_o  out  riscv_pkg::commit_rec_t  head record: pc, instr, rd, rd_data, seq.
- level_o  out  $clog2(DEPTH+1)  current occupancy.
- drop_cnt_o  out  16  number of dropped records; saturating.
- overflow_o  out  1  sticky; set by the first drop.

## Operation
- Sequence counter `seq`:
  - Increments by 1 on every cycle with update_i=1, whether the record is stored or dropped.
  - The stored record carries the pre-increment value.
  - Wraps modulo 2^SEQ_W.
- Push: occurs when update_i=1 and either the FIFO is not full, or a pop happens in the same cycle.
- Pop: occurs when trace_valid_o=1 and trace_ready_i=1.
- Simultaneous push and pop:
  - level_o is unchanged.
  - When full, the incoming record is accepted in place of the departing head.
  - When empty, there is no pop; the incoming record is stored and appears on the next cycle, with no bypass.
- Drop: occurs when update_i=1, the FIFO is full and there is no pop.
  - The record is discarded.
  - drop_cnt_o increments, saturating at 0xFFFF.
  - overflow_o is set.
- The output is first-word fall-through:
  - trace_valid_o = (level_o != 0).
  - trace_rec_o always shows the head entry.
  - When empty, trace_rec_o is don't-care; the bench must not check it.
- Valid/ready rules:
  - Once trace_valid_o is asserted, the head record stays stable until popped.
  - trace_ready_i may toggle freely.
- Pointers: read and write pointers are $clog2(DEPTH)+1 bits wide, with the extra MSB used for full/empty discrimination; both wrap naturally.

## Timing
- Latency from update_i to trace_valid_o is 1 cycle: a record captured at edge N is visible after edge N.
- level_o, drop_cnt_o and overflow_o update on the same edge as the push, pop or drop that changes them.
- Sustained throughput is one record per cycle in each direction.
- Reset, asserted at any edge including mid-drain:
  - Pointers clear, so the FIFO is empty.
  - seq=0, level_o=0, drop_cnt_o=0, overflow_o=0, trace_valid_o=0.
  - update_i is ignored on reset cycles; neither seq nor the drop count advances.
- Storage needs no reset; only control state is reset.

## Configuration
- Macro: COMMIT_TRACE_X0_FILTER_EN.
- Defined: a record with reg_addr_i=0 is stored with rd_data forced to 0, so x0 write-back noise never reaches the sink.
- Undefined: reg_data_i is stored verbatim for every record.
- All other behaviour is identical in both builds.

## Structure
- riscv_pkg gains:
  - typedef commit_rec_t, a packed struct: pc[XLEN], instr[XLEN], rd[5], rd_data[XLEN], seq[32].
  - Constant TRACE_DROP_W=16.
- One sub-module, trace_fifo_ram: a DEPTH x $bits(commit_rec_t) register array with one write port and one asynchronous read port.
- Pointers, counters and flags live in commit_trace_fifo.

## Test plan
- Single retire, ready=1: update_i with pc=0x80000000, instr=0x00500093, rd=1, data=5.
  - Next cycle: valid=1 with the same fields and seq=0.
  - Popped on that cycle; level returns to 0.
- Fill without drain, DEPTH=16: 20 consecutive retires with ready=0.
  - level_o=16, drop_cnt_o=4, overflow_o=1.
  - Draining yields seq 0..15 in order.
- Full with simultaneous push and pop: at level 16, ready=1 and update_i=1 for 5 cycles.
  - level_o stays 16 and drop_cnt_o stays 0.
  - Output seq values are contiguous.
- Backpressure stability: ready toggles 1010… while 8 records stream in.
  - The head is stable whenever valid=1 and ready=0.
  - All 8 records arrive in order with no duplicates.
- Reset mid-drain: at level 6 with overflow_o=1, pulse rst_i for 1 cycle.
  - All outputs return to reset values.
  - The next retire carries seq=0.
- x0 filter: retire with rd=0, data=0xDEADBEEF.
  - With COMMIT_TRACE_X0_FILTER_EN: rd_data=0.
  - Without it: rd_data=0xDEADBEEF.
